// File: rtl/gfx_pkg.sv
// gfx_pkg: raster timing defaults, color RAM word layout and intensity scaling shared by the video output path.
package gfx_pkg;
    localparam int H_TOTAL    = 456;
    localparam int H_ACTIVE   = 336;
    localparam int H_SYNC_ST  = 376;
    localparam int H_SYNC_LEN = 32;
    localparam int V_TOTAL    = 262;
    localparam int V_ACTIVE   = 240;
    localparam int V_SYNC_ST  = 248;
    localparam int V_SYNC_LEN = 3;
    localparam int PIPE_DLY   = 2;

    typedef struct packed {
        logic [3:0] i;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } cram_word_t;

    // Intensity I multiplies by I+1, so I=0 passes the raw channel through rather than going black.
    function automatic logic [7:0] scale_ch(input logic [3:0] c4, input logic [3:0] i4);
        logic [4:0] m;
        m = {1'b0, i4} + 5'd1;
        return {4'b0, c4} * {3'b0, m};
    endfunction
endpackage

// File: rtl/video_timing.sv
// video_timing: pixel/line counters and raw active/sync flags derived straight from the counters.
module video_timing #(
    parameter int H_TOTAL    = 456,
    parameter int H_ACTIVE   = 336,
    parameter int H_SYNC_ST  = 376,
    parameter int H_SYNC_LEN = 32,
    parameter int V_TOTAL    = 262,
    parameter int V_ACTIVE   = 240,
    parameter int V_SYNC_ST  = 248,
    parameter int V_SYNC_LEN = 3
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       ce_i,
    output logic [8:0] hcnt_o,
    output logic [8:0] vcnt_o,
    output logic       act_o,
    output logic       hs_o,
    output logic       vs_o
);
    logic [8:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic       h_end;

    always_comb begin
        h_end  = hcnt_q == 9'(H_TOTAL - 1);
        hcnt_d = h_end ? 9'd0 : hcnt_q + 9'd1;
        vcnt_d = !h_end ? vcnt_q : (vcnt_q == 9'(V_TOTAL - 1)) ? 9'd0 : vcnt_q + 9'd1;
        act_o  = hcnt_q < 9'(H_ACTIVE) && vcnt_q < 9'(V_ACTIVE);
        hs_o   = hcnt_q >= 9'(H_SYNC_ST) && hcnt_q < 9'(H_SYNC_ST + H_SYNC_LEN);
        vs_o   = vcnt_q >= 9'(V_SYNC_ST) && vcnt_q < 9'(V_SYNC_ST + V_SYNC_LEN);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else if (ce_i) begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign hcnt_o = hcnt_q;
    assign vcnt_o = vcnt_q;
endmodule

// File: rtl/video_out.sv
// video_out: raster timing plus IRGB-to-RGB conversion, with timing delayed to line up with color RAM data.
module video_out #(
    parameter int H_TOTAL    = gfx_pkg::H_TOTAL,
    parameter int H_ACTIVE   = gfx_pkg::H_ACTIVE,
    parameter int H_SYNC_ST  = gfx_pkg::H_SYNC_ST,
    parameter int H_SYNC_LEN = gfx_pkg::H_SYNC_LEN,
    parameter int V_TOTAL    = gfx_pkg::V_TOTAL,
    parameter int V_ACTIVE   = gfx_pkg::V_ACTIVE,
    parameter int V_SYNC_ST  = gfx_pkg::V_SYNC_ST,
    parameter int V_SYNC_LEN = gfx_pkg::V_SYNC_LEN
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        pix_ce,
    input  logic [15:0] D,
    output logic [8:0]  HPOS,
    output logic [8:0]  VPOS,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B,
    output logic        HSYNC_b,
    output logic        VSYNC_b,
    output logic        BLANK_b
);
    import gfx_pkg::*;

    logic                      act, hs, vs;
    logic [PIPE_DLY-1:0][2:0]  dly_q;
    logic [2:0]                tail;
    cram_word_t                w;
    logic [7:0]                r_d, g_d, b_d, r_q, g_q, b_q;
    logic                      blank_b_q, hsync_b_q, vsync_b_q;

    video_timing #(
        .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE), .H_SYNC_ST(H_SYNC_ST), .H_SYNC_LEN(H_SYNC_LEN),
        .V_TOTAL(V_TOTAL), .V_ACTIVE(V_ACTIVE), .V_SYNC_ST(V_SYNC_ST), .V_SYNC_LEN(V_SYNC_LEN)
    ) u_timing (
        .clk(clk), .rst_b(rst_b), .ce_i(pix_ce),
        .hcnt_o(HPOS), .vcnt_o(VPOS), .act_o(act), .hs_o(hs), .vs_o(vs)
    );

    // D arriving now belongs to the pixel whose flags sit in the last delay stage.
    always_comb begin
        w    = D;
        tail = dly_q[PIPE_DLY-1];
        r_d  = tail[2] ? scale_ch(w.r, w.i) : 8'd0;
        g_d  = tail[2] ? scale_ch(w.g, w.i) : 8'd0;
        b_d  = tail[2] ? scale_ch(w.b, w.i) : 8'd0;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            dly_q     <= '0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            blank_b_q <= 1'b0;
            hsync_b_q <= 1'b1;
            vsync_b_q <= 1'b1;
        end else if (pix_ce) begin
            dly_q     <= {dly_q[PIPE_DLY-2:0], {act, hs, vs}};
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            blank_b_q <= tail[2];
            hsync_b_q <= ~tail[1];
            vsync_b_q <= ~tail[0];
        end
    end

    assign R       = r_q;
    assign G       = g_q;
    assign B       = b_q;
    assign BLANK_b = blank_b_q;
    assign HSYNC_b = hsync_b_q;
    assign VSYNC_b = vsync_b_q;
endmodule

// File: tb/tb_video_out.sv
// tb_video_out: directed checks of reset, scaling, raster counts, pipeline alignment, clock-enable hold and mid-frame reset.
module tb_video_out;
    // Horizontal timing at defaults; frame height shortened so whole frames fit the cycle budget.
    localparam int HT = 456, HA = 336, HS = 376, HSL = 32;
    localparam int VT = 20, VA = 12, VS = 15, VSL = 3;

    logic        clk = 1'b0, rst_b = 1'b0, pix_ce = 1'b0;
    logic [15:0] D = '0;
    logic [8:0]  HPOS, VPOS;
    logic [7:0]  R, G, B;
    logic        HSYNC_b, VSYNC_b, BLANK_b;

    int checks = 0, errors = 0, hold_err = 0;
    bit d_mode = 1'b0;
    logic [8:0] h0 = '0, h1 = '0, h2 = '0, h3 = '0;

    video_out #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_ST(HS), .H_SYNC_LEN(HSL),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_ST(VS), .V_SYNC_LEN(VSL)
    ) dut (
        .clk(clk), .rst_b(rst_b), .pix_ce(pix_ce), .D(D),
        .HPOS(HPOS), .VPOS(VPOS), .R(R), .G(G), .B(B),
        .HSYNC_b(HSYNC_b), .VSYNC_b(VSYNC_b), .BLANK_b(BLANK_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One pixel beat: div-1 idle clocks (outputs must hold) then one enabled clock.
    task automatic step(input int div);
        logic [44:0] snap;
        snap = {R, G, B, HSYNC_b, VSYNC_b, BLANK_b, HPOS, VPOS};
        for (int i = 0; i < div; i++) begin
            pix_ce = (i == div - 1);
            @(posedge clk);
            #1;
            if (i < div - 1 && {R, G, B, HSYNC_b, VSYNC_b, BLANK_b, HPOS, VPOS} !== snap) hold_err++;
        end
        h3 = h2; h2 = h1; h1 = h0; h0 = HPOS;
        if (d_mode) D = {4'hF, h2[3:0], 8'h00};
    endtask

    task automatic run_frame(input int div);
        int blank_hi = 0, hs_lo = 0, vs_lo = 0, align_err = 0, first_err = 0, rises = 0;
        int hs_run = 0, hs_max = 0, vs_run = 0, vs_max = 0, hmax = 0, vmax = 0;
        int t376 = -1, tfall = -1;
        logic prev_hs, prev_bl;
        prev_hs = HSYNC_b;
        prev_bl = BLANK_b;
        for (int b = 0; b < HT * VT; b++) begin
            step(div);
            if (BLANK_b) blank_hi++;
            if (!HSYNC_b) hs_lo++;
            if (!VSYNC_b) vs_lo++;
            hs_run = HSYNC_b ? 0 : hs_run + 1;
            vs_run = VSYNC_b ? 0 : vs_run + 1;
            if (hs_run > hs_max) hs_max = hs_run;
            if (vs_run > vs_max) vs_max = vs_run;
            if (int'(HPOS) > hmax) hmax = int'(HPOS);
            if (int'(VPOS) > vmax) vmax = int'(VPOS);
            if (HPOS == 9'd376 && t376 < 0) t376 = b;
            if (prev_hs && !HSYNC_b && t376 >= 0 && tfall < 0) tfall = b;
            if (R !== (BLANK_b ? {h3[3:0], 4'h0} : 8'h00) || G !== 8'h00 || B !== 8'h00) align_err++;
            if (BLANK_b && !prev_bl) begin
                rises++;
                if (R !== 8'h00) first_err++;
            end
            prev_hs = HSYNC_b;
            prev_bl = BLANK_b;
        end
        check($sformatf("blank_hi_div%0d", div), blank_hi, HA * VA);
        check($sformatf("hsync_lo_div%0d", div), hs_lo, HSL * VT);
        check($sformatf("vsync_lo_div%0d", div), vs_lo, VSL * HT);
        check($sformatf("hsync_run_div%0d", div), hs_max, HSL);
        check($sformatf("vsync_run_div%0d", div), vs_max, VSL * HT);
        check($sformatf("hsync_lat_div%0d", div), tfall - t376, 3);
        check($sformatf("hpos_max_div%0d", div), hmax, HT - 1);
        check($sformatf("vpos_max_div%0d", div), vmax, VT - 1);
        check($sformatf("align_err_div%0d", div), align_err, 0);
        check($sformatf("line_starts_div%0d", div), rises, VA);
        check($sformatf("first_pix_div%0d", div), first_err, 0);
    endtask

    initial begin
        int ff_err = 0, ff_vis = 0, guard = 0;
        // Reset held with pix_ce high
        rst_b = 1'b0;
        pix_ce = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_R", R, 0);
        check("rst_G", G, 0);
        check("rst_B", B, 0);
        check("rst_HSYNC_b", HSYNC_b, 1);
        check("rst_VSYNC_b", VSYNC_b, 1);
        check("rst_BLANK_b", BLANK_b, 0);
        check("rst_HPOS", HPOS, 0);
        check("rst_VPOS", VPOS, 0);
        rst_b = 1'b1;

        // Scaling with fixed D; first visible output after three beats
        D = 16'hFF80;
        step(1); check("lat_blank_1", BLANK_b, 0);
        step(1); check("lat_blank_2", BLANK_b, 0);
        step(1); check("lat_blank_3", BLANK_b, 1);
        check("sc0_R", R, 240); check("sc0_G", G, 128); check("sc0_B", B, 0);
        D = 16'h0F11;
        step(1);
        check("sc1_R", R, 15); check("sc1_G", G, 1); check("sc1_B", B, 1);
        D = 16'h73A5;
        step(1);
        check("sc2_R", R, 24); check("sc2_G", G, 80); check("sc2_B", B, 40);

        // Full frame at full rate with position-tagged color
        d_mode = 1'b1;
        repeat (3) step(1);
        run_frame(1);

        // Saturated D must still be black in blanking
        d_mode = 1'b0;
        D = 16'hFFFF;
        for (int b = 0; b < HT; b++) begin
            step(1);
            if (BLANK_b) begin
                ff_vis++;
                if (R !== 8'd240 || G !== 8'd240 || B !== 8'd240) ff_err++;
            end else if (R !== 8'd0 || G !== 8'd0 || B !== 8'd0) ff_err++;
        end
        check("ffff_err", ff_err, 0);
        check("ffff_visible", ff_vis, HA);

        // Quarter-rate pixel enable
        d_mode = 1'b1;
        repeat (3) step(4);
        hold_err = 0;
        run_frame(4);
        check("hold_err", hold_err, 0);

        // Mid-frame async reset
        d_mode = 1'b0;
        D = 16'h0000;
        while (!(HPOS == 9'd200 && VPOS == 9'd10) && guard < 2 * HT * VT) begin
            step(1);
            guard++;
        end
        check("mid_found", guard < 2 * HT * VT, 1);
        check("mid_pre_blank", BLANK_b, 1);
        rst_b = 1'b0;
        #1;
        check("mid_BLANK_b", BLANK_b, 0);
        check("mid_HSYNC_b", HSYNC_b, 1);
        check("mid_VSYNC_b", VSYNC_b, 1);
        check("mid_HPOS", HPOS, 0);
        check("mid_VPOS", VPOS, 0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        step(1); check("mid_blank_1", BLANK_b, 0);
        step(1); check("mid_blank_2", BLANK_b, 0);
        step(1); check("mid_blank_3", BLANK_b, 1);
        check("mid_hpos_3", HPOS, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
